// File: rtl/serial_subtractor16.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor16
//  Function : Multi-cycle bit-serial subtractor, Diff = A - B - Bin.
//             A BITS_PER_CYCLE-wide full-subtractor slice and a borrow flop
//             process the operands LSB-first over WIDTH/BITS_PER_CYCLE
//             cycles. Valid/ready handshakes on both operand and result side.
//  Options  : define SUB_OVERFLOW_EN to add the registered signed-overflow
//             output Ovf.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor16 #(
    parameter int WIDTH          = 16,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Borrow
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    // Refuse to build a slice that does not tile the operand evenly.
    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_slice
        $error("BITS_PER_CYCLE must divide WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_q;
    // a_q doubles as the result shift register: each cycle the consumed
    // low slice of the minuend is dropped and the fresh difference bits
    // enter at the top, so after N cycles a_q holds the full result.
    logic [WIDTH-1:0]          a_q;
    logic [WIDTH-1:0]          b_q;
    logic                      bw_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [WIDTH-1:0]          diff_q;
    logic                      borrow_q;
    logic                      out_valid_q;

    logic [BITS_PER_CYCLE-1:0] slice_d;
    logic                      bw_d;
    logic [WIDTH-1:0]          a_d;
    logic [WIDTH-1:0]          b_d;
    logic                      last_step;

`ifdef SUB_OVERFLOW_EN
    logic                      a_msb_q;
    logic                      b_msb_q;
    logic                      ovf_q;
`endif

    // Full-subtractor slice: borrow ripples through the slice LSB-first.
    always_comb begin
        slice_d = '0;
        bw_d    = bw_q;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            slice_d[k] = a_q[k] ^ b_q[k] ^ bw_d;
            bw_d       = (~a_q[k] & b_q[k]) | (~a_q[k] & bw_d) | (b_q[k] & bw_d);
        end
    end

    if (BITS_PER_CYCLE == WIDTH) begin : g_shift_full
        assign a_d = slice_d;
    end else begin : g_shift_part
        assign a_d = {slice_d, a_q[WIDTH-1:BITS_PER_CYCLE]};
    end

    assign b_d       = b_q >> BITS_PER_CYCLE;
    assign last_step = (cnt_q == CNT_W'(N - 1));

    // Control FSM with registered datapath and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            bw_q        <= 1'b0;
            cnt_q       <= '0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= A;
                        b_q     <= B;
                        bw_q    <= Bin;
                        cnt_q   <= '0;
`ifdef SUB_OVERFLOW_EN
                        a_msb_q <= A[WIDTH-1];
                        b_msb_q <= B[WIDTH-1];
`endif
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    bw_q  <= bw_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_step) begin
                        diff_q      <= a_d;
                        borrow_q    <= bw_d;
                        out_valid_q <= 1'b1;
`ifdef SUB_OVERFLOW_EN
                        ovf_q       <= (a_msb_q != b_msb_q) && (a_d[WIDTH-1] != a_msb_q);
`endif
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign Diff      = diff_q;
    assign Borrow    = borrow_q;
`ifdef SUB_OVERFLOW_EN
    assign Ovf       = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor16.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor16
//  Function : Self-checking bench for serial_subtractor16 (default 1-bit
//             slice) plus a 4-bit-slice instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor16;

    localparam int N = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Diff;
    logic        Borrow;

    logic        in_valid4;
    logic        in_ready4;
    logic [15:0] A4;
    logic [15:0] B4;
    logic        Bin4;
    logic        out_valid4;
    logic        out_ready4;
    logic [15:0] Diff4;
    logic        Borrow4;

`ifdef SUB_OVERFLOW_EN
    logic        Ovf;
    logic        Ovf4;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_subtractor16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Borrow    (Borrow)
`ifdef SUB_OVERFLOW_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    serial_subtractor16 #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .A         (A4),
        .B         (B4),
        .Bin       (Bin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .Diff      (Diff4),
        .Borrow    (Borrow4)
`ifdef SUB_OVERFLOW_EN
        ,
        .Ovf       (Ovf4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- behavioural model of the default instance -----------
    // Result is plain arithmetic; timing is "result appears N edges after
    // acceptance, held until consumed".
    logic        m_busy;
    int          m_left;
    logic        m_valid;
    logic [15:0] m_diff;
    logic        m_borrow;
    logic [15:0] m_pend_diff;
    logic        m_pend_borrow;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy   <= 1'b0;
            m_left   <= 0;
            m_valid  <= 1'b0;
            m_diff   <= '0;
            m_borrow <= 1'b0;
        end else if (!m_busy && !m_valid) begin
            if (in_valid) begin
                m_pend_diff   <= A - B - {15'd0, Bin};
                m_pend_borrow <= ({1'b0, A} < ({1'b0, B} + {16'd0, Bin}));
                m_left        <= N;
                m_busy        <= 1'b1;
            end
        end else if (m_busy) begin
            if (m_left == 1) begin
                m_busy   <= 1'b0;
                m_valid  <= 1'b1;
                m_diff   <= m_pend_diff;
                m_borrow <= m_pend_borrow;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("cyc_in_ready",  {31'd0, in_ready},  {31'd0, (!m_busy && !m_valid)});
        chk("cyc_diff",      {16'd0, Diff},      {16'd0, m_diff});
        chk("cyc_borrow",    {31'd0, Borrow},    {31'd0, m_borrow});
    end

    // One operation on the default instance with hand-computed expectations.
    // During `hold` cycles of backpressure new operands are offered.
    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, input logic [15:0] ed, input logic eb, input int hold);
        int lat;
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = 16'hDEAD; B = 16'hBEEF; Bin = 1'b1;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, lat, N);
        chk({name, "_diff"}, {16'd0, Diff}, {16'd0, ed});
        chk({name, "_borrow"}, {31'd0, Borrow}, {31'd0, eb});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            A = 16'(i * 16'h1111); B = 16'h0101;
            @(posedge clk); #1;
            chk({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({name, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
            chk({name, "_hold_diff"}, {16'd0, Diff}, {16'd0, ed});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk({name, "_release_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_release_ready"}, {31'd0, in_ready}, 32'd1);
        chk({name, "_release_diff"}, {16'd0, Diff}, {16'd0, ed});
    endtask

    // One operation on the 4-bit-slice instance.
    task automatic do_op4(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input logic [15:0] ed, input logic eb);
        int lat;
        A4 = a; B4 = b; Bin4 = bin; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, lat, 4);
        chk({name, "_diff"}, {16'd0, Diff4}, {16'd0, ed});
        chk({name, "_borrow"}, {31'd0, Borrow4}, {31'd0, eb});
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        chk({name, "_release"}, {31'd0, in_ready4}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Bin = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; A4 = '0; B4 = '0; Bin4 = 1'b0;
        #2;
        chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_diff",      {16'd0, Diff},      32'd0);
        chk("reset_borrow",    {31'd0, Borrow},    32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("op_basic",   16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 0);
        chk("model_pin_basic", {16'd0, m_diff}, 32'h1000);
        do_op("op_under",   16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 0);
        chk("model_pin_under", {31'd0, m_borrow}, 32'd1);
        do_op("op_allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);
        do_op("op_bp",      16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 5);
        chk("model_pin_bp", {16'd0, m_diff}, 32'h00F0);

        // Reset in the middle of a run: partial result discarded at once.
        A = 16'h4321; B = 16'h1111; Bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_diff",      {16'd0, Diff},      32'd0);
        chk("midrst_borrow",    {31'd0, Borrow},    32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("op_after_rst", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 0);
        do_op("op_mid",       16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 0);

        do_op4("op4_abcd", 16'hABCD, 16'h1111, 1'b1, 16'h9ABB, 1'b0);
        do_op4("op4_wrap", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
